line_buf_unit: RTL

Line-buffer memory stage that sits directly upstream of the control unit. It accepts the raster pixel stream and writes each image row into one of NM rotating row buffers. It reports per-buffer full and minimum-fill status, and serves one registered read per buffer per cycle at the column addresses issued by the control unit. Buffers are released for refill when the control unit pulses `mem_used`.

---
 rtl/conveng_pkg.sv | 21 ++
 rtl/line_buf_unit_ram.sv | 28 ++
 rtl/line_buf_unit.sv | 96 +++++++++
 3 files changed

// File: rtl/conveng_pkg.sv
// Shared definitions for the convolution engine line-buffer and control stages.
package conveng_pkg;

    localparam int XB_DEF = 10;
    localparam int YB_DEF = 10;
    localparam int PB_DEF = 8;
    localparam int NM_DEF = 4;

    typedef logic [PB_DEF-1:0] pix_t;

    // True when at least k+1 of the low n bits of vec are set.
    function automatic logic fill_at_least(input logic [31:0] vec, input int n, input int k);
        int cnt;
        cnt = 0;
        for (int b = 0; b < 32; b++) begin
            if (b < n) cnt = cnt + int'(vec[b]);
        end
        return (cnt >= k + 1);
    endfunction

endpackage

// File: rtl/line_buf_unit_ram.sv
// One row buffer: single write port, registered read port (read-before-write).
module lb_ram
    import conveng_pkg::*;
#(
    parameter int XB = XB_DEF,
    parameter int PB = PB_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [XB-1:0] wr_addr,
    input  logic [PB-1:0] wr_data,
    input  logic [XB-1:0] rd_addr,
    output logic [PB-1:0] rd_data
);

    logic [PB-1:0] mem [2**XB];

    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) rd_data <= '0;
        else     rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/line_buf_unit.sv
// Rotating row-buffer stage: writes raster rows into NM buffers and serves
// one registered read per buffer per cycle to the control unit.
module line_buf_unit
    import conveng_pkg::*;
#(
    parameter int XB = XB_DEF,
    parameter int YB = YB_DEF,
    parameter int PB = PB_DEF,
    parameter int NM = NM_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XB-1:0]    cfg_width,
    input  logic [YB-1:0]    cfg_height,
    input  logic [PB-1:0]    in_pix,
    input  logic             in_valid,
    input  logic             in_sof,
    output logic             in_ready,
    input  logic [NM-1:0]    mem_used,
    input  logic [XB*NM-1:0] mb_rd_addr,
    output logic [NM-1:0]    mb_full,
    output logic [NM-1:0]    mb_minfill,
    output logic [PB*NM-1:0] pu_data,
    output logic             frame_in_done,
    output logic             err_sof
);

    localparam int SB = (NM > 1) ? $clog2(NM) : 1;

    logic [SB-1:0] wr_sel;
    logic [XB-1:0] wr_col;
    logic [YB-1:0] wr_row;

    logic          accept;
    logic          sof_err;
    logic          row_done;
    logic          last_row;
    logic [XB-1:0] wr_addr;
    logic [NM-1:0] set_mask;
    logic [SB-1:0] sel_next;

    assign in_ready = !mb_full[wr_sel];
    assign accept   = in_valid && in_ready && !rst;
    // A stray SOF restarts the frame in place: the beat lands at column 0.
    assign sof_err  = accept && in_sof && ((wr_col != '0) || (wr_row != '0));
    assign row_done = accept && !sof_err && (wr_col == cfg_width - 1'b1);
    assign last_row = (wr_row == cfg_height - 1'b1);
    assign wr_addr  = sof_err ? '0 : wr_col;
    assign set_mask = row_done ? (NM'(1) << wr_sel) : '0;
    assign sel_next = (wr_sel == SB'(NM - 1)) ? '0 : wr_sel + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_sel        <= '0;
            wr_col        <= '0;
            wr_row        <= '0;
            mb_full       <= '0;
            frame_in_done <= 1'b0;
            err_sof       <= 1'b0;
        end else begin
            mb_full       <= (mb_full & ~mem_used) | set_mask;
            frame_in_done <= row_done && last_row;
            if (sof_err) begin
                err_sof <= 1'b1;
                wr_col  <= XB'(1);
                wr_row  <= '0;
            end else if (row_done) begin
                wr_col <= '0;
                wr_sel <= sel_next;
                wr_row <= last_row ? '0 : wr_row + 1'b1;
            end else if (accept) begin
                wr_col <= wr_col + 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NM; k++) begin : g_minfill
        assign mb_minfill[k] = fill_at_least(32'(mb_full), NM, k);
    end

    for (genvar i = 0; i < NM; i++) begin : g_buf
        lb_ram #(
            .XB(XB),
            .PB(PB)
        ) u_ram (
            .clk    (clk),
            .rst    (rst),
            .we     (accept && (wr_sel == SB'(i))),
            .wr_addr(wr_addr),
            .wr_data(in_pix),
            .rd_addr(mb_rd_addr[i*XB +: XB]),
            .rd_data(pu_data[i*PB +: PB])
        );
    end

endmodule
